// File: rtl/magma_encoder_scheduler_if.sv
// Bus bundle between NREQ requesters, one pipelined Magma encoder and the scheduler.
interface magma_encoder_scheduler_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*64-1:0]  req_block;
   logic [NREQ*256-1:0] req_key;
   logic [63:0]         enc_block;
   logic [255:0]        enc_key;
   logic [63:0]         enc_encoded;
   logic [NREQ-1:0]     rsp_valid;
   logic [63:0]         rsp_data;
   logic                drain_req;
   logic                drained;
   logic [7:0]          inflight;

   modport master (
      output req_valid, req_block, req_key, enc_encoded, drain_req,
      input  req_ready, enc_block, enc_key, rsp_valid, rsp_data, drained, inflight
   );

   modport slave (
      input  req_valid, req_block, req_key, enc_encoded, drain_req,
      output req_ready, enc_block, enc_key, rsp_valid, rsp_data, drained, inflight
   );
endinterface

// File: rtl/magma_encoder_scheduler.sv
// Round-robin scheduler sharing one LATENCY-deep pipelined Magma encoder among NREQ requesters.
// Defining MAGMA_SCHED_STATS_EN adds free-running issue_count / rsp_count outputs.
//
// state   | meaning
// RUN     | granting requests round-robin
// DRAIN   | no new grants, waiting for inflight to reach zero
// DRAINED | pipeline empty, waiting for drain_req to drop
module magma_encoder_scheduler #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 128
) (
   input logic clk,
   input logic rst,
   magma_encoder_scheduler_if.slave bus
`ifdef MAGMA_SCHED_STATS_EN
   ,
   output logic [31:0] issue_count,
   output logic [31:0] rsp_count
`endif
);
   localparam int OW = $clog2(NREQ);

   typedef logic [OW-1:0] owner_t;
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   owner_t             r_ptr;
   owner_t             w_gnt_idx;
   logic [NREQ-1:0]    w_grant;
   logic               w_hs;

   logic [63:0]        r_enc_block;
   logic [255:0]       r_enc_key;
   logic               r_enc_vld;
   owner_t             r_enc_own;

   logic [LATENCY-1:0] r_tag_vld;
   owner_t             r_tag_own [LATENCY];
   logic               w_rsp_fire;
   owner_t             w_rsp_own;

   logic [NREQ-1:0]    r_rsp_valid;
   logic [63:0]        r_rsp_data;
   logic [7:0]         r_inflight;

   function automatic owner_t rr_next(input owner_t base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end
      return owner_t'(sum);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (bus.drain_req) w_state_nxt = DRAIN;
         DRAIN:   if (r_inflight == 8'd0) w_state_nxt = DRAINED;
         DRAINED: if (!bus.drain_req) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // Grant is withheld in the very cycle drain_req rises, before the state has left RUN.
   always_comb begin
      w_grant   = '0;
      w_gnt_idx = '0;
      w_hs      = 1'b0;
      if (!rst && r_state == RUN && !bus.drain_req) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!w_hs && bus.req_valid[rr_next(r_ptr, k)]) begin
               w_hs      = 1'b1;
               w_gnt_idx = rr_next(r_ptr, k);
            end
         end
         w_grant[w_gnt_idx] = w_hs;
      end
   end

   assign bus.req_ready = w_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_enc_block <= '0;
         r_enc_key   <= '0;
         r_enc_vld   <= 1'b0;
         r_enc_own   <= '0;
      end else begin
         r_enc_vld <= w_hs;
         r_enc_own <= w_gnt_idx;
         if (w_hs) begin
            r_enc_block <= bus.req_block[int'(w_gnt_idx)*64 +: 64];
            r_enc_key   <= bus.req_key[int'(w_gnt_idx)*256 +: 256];
            r_ptr       <= rr_next(w_gnt_idx, 1);
         end
      end
   end

   // The enc_* register is tag stage zero; LATENCY further stages line up with enc_encoded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_vld <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[LATENCY-2:0], r_enc_vld};
      end
   end

   always_ff @(posedge clk) begin
      r_tag_own[0] <= r_enc_own;
      for (int s = 1; s < LATENCY; s++) begin
         r_tag_own[s] <= r_tag_own[s-1];
      end
   end

   assign w_rsp_fire = r_tag_vld[LATENCY-1];
   assign w_rsp_own  = r_tag_own[LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= '0;
         if (w_rsp_fire) begin
            r_rsp_valid[w_rsp_own] <= 1'b1;
            r_rsp_data             <= bus.enc_encoded;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else if (w_hs && !w_rsp_fire) begin
         r_inflight <= r_inflight + 8'd1;
      end else if (!w_hs && w_rsp_fire) begin
         r_inflight <= r_inflight - 8'd1;
      end
   end

   assign bus.enc_block = r_enc_block;
   assign bus.enc_key   = r_enc_key;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.drained   = (r_state == DRAINED);
   assign bus.inflight  = r_inflight;

`ifdef MAGMA_SCHED_STATS_EN
   logic [31:0] r_issue_count;
   logic [31:0] r_rsp_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_count <= '0;
         r_rsp_count   <= '0;
      end else begin
         if (w_hs) begin
            r_issue_count <= r_issue_count + 32'd1;
         end
         if (w_rsp_fire) begin
            r_rsp_count <= r_rsp_count + 32'd1;
         end
      end
   end

   assign issue_count = r_issue_count;
   assign rsp_count   = r_rsp_count;
`endif

endmodule

// File: tb/tb_magma_encoder_scheduler.sv
// Scoreboard bench for magma_encoder_scheduler with a behavioural LATENCY-stage Magma encoder.
// Stats checks are compiled only when MAGMA_SCHED_STATS_EN is defined.
module tb_magma_encoder_scheduler;
   localparam int NREQ    = 4;
   localparam int LATENCY = 128;

   localparam logic [63:0]  RFC_PT  = 64'hfedcba9876543210;
   localparam logic [255:0] RFC_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  RFC_CT  = 64'h4ee901e5c2d8ca3d;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   magma_encoder_scheduler_if #(.NREQ(NREQ)) bus ();

`ifdef MAGMA_SCHED_STATS_EN
   logic [31:0] issue_count;
   logic [31:0] rsp_count;
`endif

   magma_encoder_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef MAGMA_SCHED_STATS_EN
      ,
      .issue_count (issue_count),
      .rsp_count   (rsp_count)
`endif
   );

   // ---------------- behavioural Magma (GOST R 34.12-2015, 64-bit) ----------------
   function automatic logic [63:0] sbox_row(input int j);
      case (j)
         0: return 64'hc462a5b9e8d703f1;
         1: return 64'h68239a5c1e47bd0f;
         2: return 64'hb3582fade174c960;
         3: return 64'hc821d4f670a53e9b;
         4: return 64'h7f5a816d093eb42c;
         5: return 64'h5df692cab78143e0;
         6: return 64'h8e25691cf4b0da37;
         default: return 64'h17ed05834fa69cb2;
      endcase
   endfunction

   function automatic logic [31:0] magma_g(input logic [31:0] k, input logic [31:0] a);
      logic [31:0] s;
      logic [31:0] t;
      logic [63:0] row;
      s = a + k;
      t = '0;
      for (int j = 0; j < 8; j++) begin
         row = sbox_row(j);
         t[4*j +: 4] = row[60 - 4*int'(s[4*j +: 4]) +: 4];
      end
      return {t[20:0], t[31:21]};
   endfunction

   function automatic logic [63:0] magma_enc(input logic [63:0] blk_in, input logic [255:0] key_in);
      logic [31:0] a1;
      logic [31:0] a0;
      logic [31:0] tmp;
      logic [31:0] rk;
      int ki;
      a1 = blk_in[63:32];
      a0 = blk_in[31:0];
      for (int i = 0; i < 32; i++) begin
         ki  = (i < 24) ? (i % 8) : (7 - (i % 8));
         rk  = key_in[255 - 32*ki -: 32];
         tmp = magma_g(rk, a0) ^ a1;
         if (i < 31) begin
            a1 = a0;
            a0 = tmp;
         end else begin
            a1 = tmp;
         end
      end
      return {a1, a0};
   endfunction

   logic [63:0] enc_pipe [LATENCY];
   always @(posedge clk) begin
      enc_pipe[0] <= magma_enc(bus.enc_block, bus.enc_key);
      for (int s = 1; s < LATENCY; s++) begin
         enc_pipe[s] <= enc_pipe[s-1];
      end
   end
   assign bus.enc_encoded = enc_pipe[LATENCY-1];

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [NREQ-1:0] own;
      logic [63:0]     data;
      int              issue_cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_rsp_cyc = 0;
   bit          force_rfc = 1'b0;
   logic [63:0]  blk [NREQ];
   logic [255:0] key [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rsp_valid != '0) begin
         last_rsp_cyc = cyc;
         if (sb_q.size() == 0) begin
            check("unexpected_rsp", bus.rsp_valid, '0);
         end else begin
            mon_e = sb_q.pop_front();
            check("rsp_owner", bus.rsp_valid, mon_e.own);
            check("rsp_data", bus.rsp_data, mon_e.data);
            check("rsp_latency", cyc - mon_e.issue_cyc, LATENCY + 1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_lanes();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_block[64*i +: 64]   = blk[i];
         bus.req_key[256*i +: 256]   = key[i];
      end
   endtask

   // One cycle: present vld, check the grant, queue the expected response (exp_g < 0: no grant).
   task automatic step(input logic [NREQ-1:0] vld, input int exp_g, input string name);
      logic [NREQ-1:0] exp_rdy;
      exp_t e;
      @(negedge clk);
      bus.req_valid = vld;
      load_lanes();
      #1;
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      check(name, bus.req_ready, exp_rdy);
      if (exp_g >= 0) begin
         e.own       = exp_rdy;
         e.data      = force_rfc ? RFC_CT : magma_enc(blk[exp_g], key[exp_g]);
         e.issue_cyc = cyc + 1;
         sb_q.push_back(e);
         blk[exp_g] = blk[exp_g] + 64'h0001020304050607;
         key[exp_g] = {key[exp_g][254:0], key[exp_g][255]};
      end
   endtask

   task automatic wait_empty(input int budget, input string name);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         bus.req_valid = '0;
         #2;
         if (sb_q.size() == 0) break;
      end
      check({name, "_pending"}, sb_q.size(), 0);
      check({name, "_inflight"}, bus.inflight, 8'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = '1;
      load_lanes();
      #1;
      check("ready_in_reset", bus.req_ready, '0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      #1;
      check("post_rst_inflight", bus.inflight, 8'd0);
      check("post_rst_rsp_valid", bus.rsp_valid, '0);
      check("post_rst_drained", bus.drained, 1'b0);
      check("post_rst_enc_block", bus.enc_block, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit got;
      blk[0] = RFC_PT;
      key[0] = RFC_KEY;
      for (int i = 1; i < NREQ; i++) begin
         blk[i] = 64'h0123456789abcdef + 64'(i) * 64'h0101010101010101;
         key[i] = RFC_KEY ^ {8{32'(i) * 32'h11111111}};
      end
      bus.drain_req = 1'b0;
      bus.req_valid = '1;
      load_lanes();

      // reset state, with every requester asking
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_req_ready", bus.req_ready, '0);
      check("rst_rsp_valid", bus.rsp_valid, '0);
      check("rst_rsp_data", bus.rsp_data, 64'd0);
      check("rst_enc_block", bus.enc_block, 64'd0);
      check("rst_enc_key", bus.enc_key, 256'd0);
      check("rst_inflight", bus.inflight, 8'd0);
      check("rst_drained", bus.drained, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;

      // single request: RFC vector from requester 0
      force_rfc = 1'b1;
      step(4'b0001, 0, "single_grant");
      force_rfc = 1'b0;
      wait_empty(200, "single");

      // pointer skipping from ptr=0 with only requesters 1 and 3 valid
      pulse_reset();
      step(4'b1010, 1, "skip_grant");
      step(4'b1010, 3, "skip_grant");
      step(4'b1010, 1, "skip_grant");
      step(4'b1010, 3, "skip_grant");
      wait_empty(200, "skip");

      // fairness: all valid, ptr is 0 after the last grant to 3
      for (int k = 0; k < 8; k++) step(4'b1111, k % 4, "fair_grant");
      wait_empty(200, "fair");

      // drain with 10 in flight
      for (int k = 0; k < 10; k++) step(4'b1111, k % 4, "drain_fill_grant");
      @(negedge clk);
      bus.drain_req = 1'b1;
      bus.req_valid = '1;
      #1;
      check("drain_first_cycle_ready", bus.req_ready, '0);
      check("drain_inflight10", bus.inflight, 8'd10);
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         #2;
         check("drain_no_grant", bus.req_ready, '0);
         if (bus.drained) begin
            got = 1'b1;
            check("drained_rise_cycle", cyc, last_rsp_cyc + 1);
            check("drained_pending", sb_q.size(), 0);
         end
      end
      if (!got) check("drained_rise", bus.drained, 1'b1);
      @(negedge clk);
      bus.drain_req = 1'b0;
      #1;
      check("release_same_cycle_ready", bus.req_ready, '0);
      step(4'b1111, 2, "resume_grant");
      wait_empty(200, "resume");

      // reset mid-flight: five issued then discarded
      for (int k = 0; k < 5; k++) step(4'b1111, (k + 3) % 4, "midrst_grant");
      pulse_reset();
      step(4'b0001, 0, "after_rst_grant");
      wait_empty(300, "after_rst");

`ifdef MAGMA_SCHED_STATS_EN
      pulse_reset();
      check("stats_rst_issue", issue_count, 32'd0);
      check("stats_rst_rsp", rsp_count, 32'd0);
      for (int k = 0; k < 300; k++) step(4'b1111, k % 4, "stats_grant");
      wait_empty(400, "stats");
      check("stats_issue_300", issue_count, 32'd300);
      check("stats_rsp_300", rsp_count, 32'd300);
      @(negedge clk);
      dut.r_issue_count = 32'hFFFFFFFF;
      dut.r_rsp_count   = 32'hFFFFFFFF;
      step(4'b0001, 0, "stats_wrap_grant");
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      check("stats_issue_wrap", issue_count, 32'd0);
      check("stats_rsp_hold", rsp_count, 32'hFFFFFFFF);
      wait_empty(200, "stats_wrap");
      check("stats_rsp_wrap", rsp_count, 32'd0);
`endif

      repeat (5) @(negedge clk);
      check("scoreboard_leftover", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
